random_lfsr: RTL

Parametrised pseudorandom source for ant movement and other game randomness. It is a Fibonacci LFSR of configurable width with a maximal-length tap set. A request/valid handshake delivers each draw after a configurable number of decorrelating shifts. It guards against the all-zero lock-up state and can optionally report when the sequence period wraps.

---
 rtl/random_lfsr.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/random_lfsr.sv
// random_lfsr: maximal-length Fibonacci LFSR that delivers one draw per req after STEPS shifts.
// Define RAND_PERIOD_CNT_EN to add sequence-period wrap detection on the wrap output.
module random_lfsr #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STEPS      = 8,
    parameter logic [31:0] RESET_SEED = 32'd1
) (
    input  logic             rand_clk,
    input  logic             Reset,
    input  logic             LD_seed,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             busy,
    output logic             wrap
);

    typedef enum logic {IDLE = 1'b0, STEP = 1'b1} state_t;

    // XAPP052 tap sets; tap position t lands on bit t-1
    function automatic logic [31:0] tap_mask(input int unsigned w);
        logic [31:0] m;
        case (w)
            32'd3:   m = 32'h0000_0006;
            32'd4:   m = 32'h0000_000C;
            32'd5:   m = 32'h0000_0014;
            32'd6:   m = 32'h0000_0030;
            32'd7:   m = 32'h0000_0060;
            32'd8:   m = 32'h0000_00B8;
            32'd9:   m = 32'h0000_0110;
            32'd10:  m = 32'h0000_0240;
            32'd11:  m = 32'h0000_0500;
            32'd12:  m = 32'h0000_0829;
            32'd13:  m = 32'h0000_100D;
            32'd14:  m = 32'h0000_2015;
            32'd15:  m = 32'h0000_6000;
            32'd16:  m = 32'h0000_D008;
            32'd17:  m = 32'h0001_2000;
            32'd18:  m = 32'h0002_0400;
            32'd19:  m = 32'h0004_0023;
            32'd20:  m = 32'h0009_0000;
            32'd21:  m = 32'h0014_0000;
            32'd22:  m = 32'h0030_0000;
            32'd23:  m = 32'h0042_0000;
            32'd24:  m = 32'h00E1_0000;
            32'd25:  m = 32'h0120_0000;
            32'd26:  m = 32'h0200_0023;
            32'd27:  m = 32'h0400_0013;
            32'd28:  m = 32'h0900_0000;
            32'd29:  m = 32'h1400_0000;
            32'd30:  m = 32'h2000_0029;
            32'd31:  m = 32'h4800_0000;
            32'd32:  m = 32'h8020_0003;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    localparam logic [31:0]      TAP_FULL    = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS        = TAP_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RESET_STATE = (RESET_SEED[WIDTH-1:0] == {WIDTH{1'b0}}) ?
                                               ONE : RESET_SEED[WIDTH-1:0];
    localparam logic [5:0]       STEP_LAST   = 6'(STEPS - 32'd1);

    function automatic logic parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // The all-zero state is a lock-up point, so it is never loaded
    function automatic logic [WIDTH-1:0] seed_guard(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] g;
        if (s == {WIDTH{1'b0}}) begin
            g = ONE;
        end else begin
            g = s;
        end
        return g;
    endfunction

    if (WIDTH < 32'd3 || WIDTH > 32'd32) begin : g_bad_width
        $error("random_lfsr: WIDTH %0d outside legal range 3..32", WIDTH);
    end
    if (STEPS < 32'd1 || STEPS > 32'd64) begin : g_bad_steps
        $error("random_lfsr: STEPS %0d outside legal range 1..64", STEPS);
    end

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] lfsr_r;
    logic [WIDTH-1:0] lfsr_nx_s;
    logic [WIDTH-1:0] shifted_s;
    logic [5:0]       cnt_r;
    logic [5:0]       cnt_nx_s;
    logic [WIDTH-1:0] value_r;
    logic [WIDTH-1:0] value_nx_s;
    logic             valid_r;
    logic             valid_nx_s;
    logic             busy_r;
    logic             shift_s;

    assign shifted_s = {lfsr_r[WIDTH-2:0], parity(lfsr_r & TAPS)};

    // Next-state, shift and draw-completion decode; a seed load overrides everything
    always_comb begin
        state_nx_s = state_r;
        lfsr_nx_s  = lfsr_r;
        cnt_nx_s   = cnt_r;
        value_nx_s = value_r;
        valid_nx_s = 1'b0;
        shift_s    = 1'b0;
        if (LD_seed) begin
            state_nx_s = IDLE;
            lfsr_nx_s  = seed_guard(seed);
            cnt_nx_s   = 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        state_nx_s = STEP;
                        cnt_nx_s   = STEP_LAST;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                STEP: begin
                    shift_s   = 1'b1;
                    lfsr_nx_s = shifted_s;
                    if (cnt_r == 6'd0) begin
                        state_nx_s = IDLE;
                        value_nx_s = shifted_s;
                        valid_nx_s = 1'b1;
                    end else begin
                        cnt_nx_s = cnt_r - 6'd1;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge rand_clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // LFSR, shift counter and registered outputs
    always_ff @(posedge rand_clk or posedge Reset) begin
        if (Reset) begin
            lfsr_r  <= RESET_STATE;
            cnt_r   <= 6'd0;
            value_r <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            lfsr_r  <= lfsr_nx_s;
            cnt_r   <= cnt_nx_s;
            value_r <= value_nx_s;
            valid_r <= valid_nx_s;
            busy_r  <= (state_nx_s == STEP);
        end
    end

    assign value = value_r;
    assign valid = valid_r;
    assign busy  = busy_r;

`ifdef RAND_PERIOD_CNT_EN
    logic [WIDTH-1:0] seed_rec_r;
    logic [WIDTH-1:0] period_cnt_r;
    logic             wrap_r;

    // Period tracking: a full period has elapsed when a shift lands back on the recorded seed
    always_ff @(posedge rand_clk or posedge Reset) begin
        if (Reset) begin
            seed_rec_r   <= RESET_STATE;
            period_cnt_r <= {WIDTH{1'b0}};
            wrap_r       <= 1'b0;
        end else if (LD_seed) begin
            seed_rec_r   <= seed_guard(seed);
            period_cnt_r <= {WIDTH{1'b0}};
            wrap_r       <= 1'b0;
        end else begin
            wrap_r <= shift_s && (shifted_s == seed_rec_r);
            if (wrap_r) begin
                period_cnt_r <= shift_s ? ONE : {WIDTH{1'b0}};
            end else if (shift_s) begin
                period_cnt_r <= period_cnt_r + ONE;
            end else begin
                period_cnt_r <= period_cnt_r;
            end
        end
    end

    assign wrap = wrap_r;
`else
    assign wrap = 1'b0;
`endif

endmodule
